object_renderer: RTL and testbench
==================================

// Module: object_renderer
// PURPOSE
//  Responder side of the game control handshake. The control FSM issues a
//  draw command for one object (bird or wall) identified by its state code.
//  This block erases the object's previous rectangle, draws the new one,
//  streams the pixels to the VGA adapter, and then returns a one-cycle done
//  flag. That flag is the "flag" input the bird and wall controllers wait on.
// PARAMETERS
//  SCREEN_W   160     visible width in pixels; x >= SCREEN_W is clipped
//  SCREEN_H   120     visible height in pixels; y >= SCREEN_H is clipped
//  BG_COLOUR  3'b000  colour used for the erase pass
// PORTS
//  clk         in   1  system clock
//  resetn      in   1  asynchronous active-low reset
//  start       in   1  command strobe; sampled only in IDLE
//  obj_id      in   4  object code (cur_state value); indexes the position table
//  obj_x       in   8  new top-left x
//  obj_y       in   7  new top-left y
//  obj_w       in   8  new width in pixels; 0 means no draw pass
//  obj_h       in   7  new height in pixels; 0 means no draw pass
//  obj_colour  in   3  fill colour for the draw pass
//  busy        out  1  high from the cycle after start is accepted through DONE
//  done        out  1  one-cycle pulse at end of command
//  vga_x       out  8  pixel x to the adapter
//  vga_y       out  7  pixel y to the adapter
//  vga_colour  out  3  pixel colour
//  vga_plot    out  1  write enable for the adapter
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE; busy, done, vga_plot = 0;
//    vga_x, vga_y, vga_colour = 0; all 16 table valid bits cleared.
//  - Position table: 16 entries indexed by obj_id, each {valid,x,y,w,h}.
//    Holds the last rectangle drawn for each id.
//  - FSM states: IDLE -> LOAD -> ERASE -> DRAW -> DONE -> IDLE.
//  - IDLE: if start=1, latch the obj_* inputs and go to LOAD. start in any
//    other state is ignored; there is no queueing.
//  - LOAD (1 cycle): read table[obj_id] and clear the pixel counters.
//    - valid=1 and old w,h nonzero: go to ERASE.
//    - otherwise, new w,h nonzero: go to DRAW.
//    - otherwise: go to DONE.
//  - ERASE: one pixel per cycle over the old rectangle, row-major (x inner,
//    y outer), colour = BG_COLOUR. Takes exactly w_old*h_old cycles, then
//    goes to DRAW, or to DONE if new w or h is 0.
//  - DRAW: same raster over the new rectangle with obj_colour. Takes exactly
//    w*h cycles.
//  - Pixel outputs are registered: vga_* for counter (cx,cy) appear in the
//    cycle the FSM holds that count. vga_x = base_x+cx and vga_y = base_y+cy,
//    with the sum computed one bit wider than the port.
//    - Clipping: if the sum overflows or is >= SCREEN_W/SCREEN_H, vga_plot=0
//      for that cycle. The cycle is still consumed, so latency is fixed.
//  - DONE (1 cycle): done=1. Write table[obj_id] = {1,x,y,w,h}, with valid=1
//    even when w or h is 0. Then go to IDLE.
//  - busy=1 in LOAD, ERASE, DRAW and DONE. vga_plot=0 outside ERASE/DRAW.
//  - Total latency, start to done: 1 + E + D + 1 cycles, where E and D are the
//    erase and draw pixel counts (0 when the pass is skipped).
//  - Same id, same position: still erases then redraws, with no special case.
//  - Reset mid-command: the command is aborted, nothing is written back, and
//    the table is cleared.
// TESTING
//  1 Reset, then start id=4'hE x=10 y=20 w=2 h=2 col=3'b110 -> no erase;
//    plots (10,20)(11,20)(10,21)(11,21) col 6; done on cycle 6 after start.
//  2 Repeat id=E with x=12 y=20 -> erase 4 pixels at (10..11,20..21) with
//    col 0, then draw at (12..13,20..21); done on cycle 10.
//  3 id=F x=158 y=118 w=4 h=4 -> 16 draw cycles; vga_plot=1 only for x in
//    {158,159} and y in {118,119} (4 plots); done on cycle 18.
//  4 w=0 on a fresh id -> done on cycle 2 after start with no vga_plot; a
//    later command on that id skips the erase pass.
//  5 start pulsed again while busy -> ignored, table and outputs unaffected;
//    a start in the cycle after done is accepted.
//  6 resetn low mid-DRAW -> outputs 0 immediately; the next command on that
//    id performs no erase.

Source files
------------

// File: rtl/object_renderer.sv
// Draw-command responder: erases an object's previous rectangle, draws the new
// one, streams registered pixels to the VGA adapter, then pulses done.
module object_renderer #(
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] obj_id,
  input  logic [7:0] obj_x,
  input  logic [6:0] obj_y,
  input  logic [7:0] obj_w,
  input  logic [6:0] obj_h,
  input  logic [2:0] obj_colour,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ERASE, S_DRAW, S_DONE
  } state_t;

  state_t     r_state, w_nstate;
  logic [7:0] r_cx, w_ncx;
  logic [6:0] r_cy, w_ncy;

  logic [3:0] r_id;
  logic [7:0] r_x, r_w;
  logic [6:0] r_y, r_h;
  logic [2:0] r_col;

  logic [15:0] r_tv;
  logic [7:0]  r_tx [16];
  logic [6:0]  r_ty [16];
  logic [7:0]  r_tw [16];
  logic [6:0]  r_th [16];

  logic [7:0] w_ox, w_ow, w_bx;
  logic [6:0] w_oy, w_oh, w_by;
  logic       w_old_ok, w_new_ok, w_act;
  logic [8:0] w_sx;
  logic [7:0] w_sy;

  // The entry for the active id is stable until DONE, so erase reads it live.
  assign w_ox     = r_tx[r_id];
  assign w_oy     = r_ty[r_id];
  assign w_ow     = r_tw[r_id];
  assign w_oh     = r_th[r_id];
  assign w_old_ok = r_tv[r_id] && (w_ow != 8'd0) && (w_oh != 7'd0);
  assign w_new_ok = (r_w != 8'd0) && (r_h != 7'd0);

  always_comb begin
    w_nstate = r_state;
    w_ncx    = r_cx;
    w_ncy    = r_cy;
    case (r_state)
      S_IDLE: if (start) w_nstate = S_LOAD;
      S_LOAD: begin
        w_ncx = 8'd0;
        w_ncy = 7'd0;
        if (w_old_ok)      w_nstate = S_ERASE;
        else if (w_new_ok) w_nstate = S_DRAW;
        else               w_nstate = S_DONE;
      end
      S_ERASE: begin
        if (r_cx == w_ow - 8'd1) begin
          w_ncx = 8'd0;
          if (r_cy == w_oh - 7'd1) begin
            w_ncy    = 7'd0;
            w_nstate = w_new_ok ? S_DRAW : S_DONE;
          end else begin
            w_ncy = r_cy + 7'd1;
          end
        end else begin
          w_ncx = r_cx + 8'd1;
        end
      end
      S_DRAW: begin
        if (r_cx == r_w - 8'd1) begin
          w_ncx = 8'd0;
          if (r_cy == r_h - 7'd1) begin
            w_ncy    = 7'd0;
            w_nstate = S_DONE;
          end else begin
            w_ncy = r_cy + 7'd1;
          end
        end else begin
          w_ncx = r_cx + 8'd1;
        end
      end
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Pixel registers follow the next count so they line up with the state.
  assign w_act = (w_nstate == S_ERASE) || (w_nstate == S_DRAW);
  assign w_bx  = (w_nstate == S_ERASE) ? w_ox : r_x;
  assign w_by  = (w_nstate == S_ERASE) ? w_oy : r_y;
  assign w_sx  = {1'b0, w_bx} + {1'b0, w_ncx};
  assign w_sy  = {1'b0, w_by} + {1'b0, w_ncy};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cx       <= 8'd0;
      r_cy       <= 7'd0;
      r_id       <= 4'd0;
      r_x        <= 8'd0;
      r_y        <= 7'd0;
      r_w        <= 8'd0;
      r_h        <= 7'd0;
      r_col      <= 3'd0;
      r_tv       <= 16'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
      vga_plot   <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_cx       <= w_ncx;
      r_cy       <= w_ncy;
      busy       <= (w_nstate != S_IDLE);
      done       <= (w_nstate == S_DONE);
      vga_plot   <= w_act && (w_sx < 9'(SCREEN_W))
                          && (w_sy < 8'(SCREEN_H));
      vga_x      <= w_act ? w_sx[7:0] : 8'd0;
      vga_y      <= w_act ? w_sy[6:0] : 7'd0;
      vga_colour <= (w_nstate == S_ERASE) ? BG_COLOUR :
                    (w_nstate == S_DRAW)  ? r_col : 3'd0;
      if (r_state == S_IDLE && start) begin
        r_id  <= obj_id;
        r_x   <= obj_x;
        r_y   <= obj_y;
        r_w   <= obj_w;
        r_h   <= obj_h;
        r_col <= obj_colour;
      end
      if (r_state == S_DONE) r_tv[r_id] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_DONE) begin
      r_tx[r_id] <= r_x;
      r_ty[r_id] <= r_y;
      r_tw[r_id] <= r_w;
      r_th[r_id] <= r_h;
    end
  end

endmodule

// File: tb/tb_object_renderer.sv
// Scoreboard bench for object_renderer: a reference model queues expected
// pixels per command; a negedge monitor pops them as the DUT plots.
module tb_object_renderer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [3:0] obj_id = '0;
  logic [7:0] obj_x = '0;
  logic [6:0] obj_y = '0;
  logic [7:0] obj_w = '0;
  logic [6:0] obj_h = '0;
  logic [2:0] obj_colour = '0;
  logic       busy, done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  object_renderer dut (
    .clk(clk), .resetn(resetn), .start(start),
    .obj_id(obj_id), .obj_x(obj_x), .obj_y(obj_y),
    .obj_w(obj_w), .obj_h(obj_h), .obj_colour(obj_colour),
    .busy(busy), .done(done),
    .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_plots = 0;
  logic [17:0] sb [$];
  bit m_v [16];
  int m_x [16];
  int m_y [16];
  int m_w [16];
  int m_h [16];

  always @(negedge clk) begin
    if (resetn && vga_plot) begin
      logic [17:0] e;
      n_plots++;
      n_chk++;
      if (sb.size() == 0) begin
        $display("FAIL pixel_unexpected got x=%0d y=%0d c=%0d required no plot",
                 vga_x, vga_y, vga_colour);
      end else begin
        e = sb.pop_front();
        if ({vga_x, vga_y, vga_colour} !== e)
          $display("FAIL pixel got x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d",
                   vga_x, vga_y, vga_colour, e[17:10], e[9:3], e[2:0]);
        else
          n_pass++;
      end
    end
  end

  function automatic void push_rect(int bx, int by, int w, int h,
                                    logic [2:0] c);
    for (int cy = 0; cy < h; cy++)
      for (int cx = 0; cx < w; cx++)
        if (bx + cx < 160 && by + cy < 120)
          sb.push_back({8'(bx + cx), 7'(by + cy), c});
  endfunction

  function automatic int model_cmd(int id, int x, int y, int w, int h,
                                   logic [2:0] c);
    int e, d;
    e = 0;
    d = 0;
    if (m_v[id] && m_w[id] != 0 && m_h[id] != 0) begin
      e = m_w[id] * m_h[id];
      push_rect(m_x[id], m_y[id], m_w[id], m_h[id], 3'b000);
    end
    if (w != 0 && h != 0) begin
      d = w * h;
      push_rect(x, y, w, h, c);
    end
    m_v[id] = 1'b1;
    m_x[id] = x;
    m_y[id] = y;
    m_w[id] = w;
    m_h[id] = h;
    return 2 + e + d;
  endfunction

  task automatic issue(input logic [3:0] id, input logic [7:0] x,
                       input logic [6:0] y, input logic [7:0] w,
                       input logic [6:0] h, input logic [2:0] c,
                       input int pulse_at, output int lat);
    @(negedge clk);
    obj_id = id; obj_x = x; obj_y = y;
    obj_w = w; obj_h = h; obj_colour = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 1000) begin
      if (lat == pulse_at) begin
        start = 1'b1;
        obj_id = 4'h3; obj_x = 8'd50; obj_y = 7'd50;
        obj_w = 8'd1; obj_h = 7'd1; obj_colour = 3'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({busy, done, vga_plot} !== 3'b000)
      $display("FAIL reset_ctrl got %b required 000", {busy, done, vga_plot});
    else n_pass++;
    n_chk++;
    if ({vga_x, vga_y, vga_colour} !== 18'd0)
      $display("FAIL reset_pix got %h required 0", {vga_x, vga_y, vga_colour});
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic run_cmd(input string nm, input logic [3:0] id,
                         input int x, input int y, input int w, input int h,
                         input logic [2:0] c, input int pulse_at,
                         input int plots_req);
    int exp, lat, p0;
    exp = model_cmd(id, x, y, w, h, c);
    p0 = n_plots;
    issue(id, 8'(x), 7'(y), 8'(w), 7'(h), c, pulse_at, lat);
    n_chk++;
    if (lat !== exp)
      $display("FAIL %s_latency got %0d required %0d", nm, lat, exp);
    else n_pass++;
    n_chk++;
    if (sb.size() !== 0 || n_plots - p0 !== plots_req)
      $display("FAIL %s_plots got %0d (left %0d) required %0d",
               nm, n_plots - p0, sb.size(), plots_req);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s_idle got busy=%b done=%b required 0 0", nm, busy, done);
    else n_pass++;
  endtask

  task automatic test_first_draw();
    run_cmd("first", 4'hE, 10, 20, 2, 2, 3'b110, 0, 4);
  endtask

  task automatic test_erase_redraw();
    run_cmd("move", 4'hE, 12, 20, 2, 2, 3'b110, 0, 8);
    run_cmd("same", 4'hE, 12, 20, 2, 2, 3'b011, 0, 8);
  endtask

  task automatic test_clip();
    run_cmd("clip", 4'hF, 158, 118, 4, 4, 3'b101, 0, 4);
    run_cmd("ovf", 4'h1, 250, 5, 10, 1, 3'b111, 0, 0);
  endtask

  task automatic test_zero_size();
    run_cmd("zero", 4'h5, 30, 40, 0, 3, 3'b001, 0, 0);
    run_cmd("after_zero", 4'h5, 0, 0, 1, 1, 3'b100, 0, 1);
  endtask

  task automatic test_back_to_back();
    run_cmd("busy_pulse", 4'h7, 30, 30, 3, 2, 3'b101, 3, 6);
    run_cmd("b2b", 4'h3, 50, 50, 1, 1, 3'b010, 0, 1);
  endtask

  task automatic test_reset_mid();
    int exp;
    exp = model_cmd(4'h9, 40, 40, 4, 4, 3'b001);
    @(negedge clk);
    obj_id = 4'h9; obj_x = 8'd40; obj_y = 7'd40;
    obj_w = 8'd4; obj_h = 7'd4; obj_colour = 3'b001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, vga_plot, vga_x, vga_y, vga_colour} !== 21'd0)
      $display("FAIL midreset_out got busy=%b plot=%b x=%0d required 0",
               busy, vga_plot, vga_x);
    else n_pass++;
    sb.delete();
    for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run_cmd("post_reset9", 4'h9, 40, 40, 4, 4, 3'b001, 0, 16);
    run_cmd("post_resetE", 4'hE, 12, 20, 2, 2, 3'b110, 0, 4);
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_erase_redraw();
    test_clip();
    test_zero_size();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
